// File: rtl/line_buffer_ctrl.sv
// 3-line buffer controller: writes a raster stream and walks a 3x3 window center; pix_valid/in_ready handshake, in_ready low only in FLUSH.
// Write 1 cycle after accept, addresses 1 cycle after center advance, window_valid 3 cycles; LBC_BORDER_FLAG_EN adds win_border.
module line_buffer_ctrl #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int ADDRESSWIDTH = 19,
    parameter int BITWIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sof,
    input  logic                    pix_valid,
    input  logic [BITWIDTH-1:0]     gray_in,
    output logic                    in_ready,
    output logic                    we,
    output logic [ADDRESSWIDTH-1:0] wr_address,
    output logic [BITWIDTH-1:0]     gray_out,
    output logic [ADDRESSWIDTH-1:0] addr_c,
    output logic [ADDRESSWIDTH-1:0] addr_lu,
    output logic [ADDRESSWIDTH-1:0] addr_l,
    output logic [ADDRESSWIDTH-1:0] addr_ld,
    output logic [ADDRESSWIDTH-1:0] addr_u,
    output logic [ADDRESSWIDTH-1:0] addr_d,
    output logic [ADDRESSWIDTH-1:0] addr_ru,
    output logic [ADDRESSWIDTH-1:0] addr_r,
    output logic [ADDRESSWIDTH-1:0] addr_rd,
    output logic                    window_valid,
    output logic [9:0]              win_x,
    output logic [8:0]              win_y,
`ifdef LBC_BORDER_FLAG_EN
    output logic                    win_border,
`endif
    output logic                    frame_done
);

    localparam logic [ADDRESSWIDTH-1:0] ONE    = ADDRESSWIDTH'(1);
    localparam logic [ADDRESSWIDTH-1:0] W_A    = ADDRESSWIDTH'(WIDTH);
    localparam logic [ADDRESSWIDTH-1:0] N_LAST = ADDRESSWIDTH'(WIDTH * HEIGHT - 1);
    localparam logic [9:0]              X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0]              Y_LAST = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] n_q;
    logic [ADDRESSWIDTH-1:0] cm_q;
    logic [9:0]              cx_q;
    logic [8:0]              cy_q;
    logic                    start, abort, wr_en, issue, center_last;

    logic                    at_l, at_r, at_u, at_d;
    logic [ADDRESSWIDTH-1:0] row_u, row_d;
    logic [ADDRESSWIDTH-1:0] nb_lu, nb_u, nb_ru, nb_l, nb_r, nb_ld, nb_d, nb_rd;

    logic                    p1_vld, p2_vld, p1_last, p2_last, win_last;
    logic [9:0]              p1_x, p2_x;
    logic [8:0]              p1_y, p2_y;

    assign center_last = (cx_q == X_LAST) && (cy_q == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // sof restarts the frame from any accepting state; FLUSH ignores the input side.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        abort   = 1'b0;
        wr_en   = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pix_valid && sof) begin
                    start   = 1'b1;
                    wr_en   = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (pix_valid) begin
                    wr_en = 1'b1;
                    if (sof) begin
                        start = 1'b1;
                        abort = 1'b1;
                    end else if (n_q == W_A) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (pix_valid) begin
                    wr_en = 1'b1;
                    if (sof) begin
                        start   = 1'b1;
                        abort   = 1'b1;
                        state_d = FILL;
                    end else begin
                        issue = 1'b1;
                        if (n_q == N_LAST) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                issue = 1'b1;
                if (center_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b1;
            we         <= 1'b0;
            wr_address <= '0;
            gray_out   <= '0;
            n_q        <= '0;
        end else begin
            in_ready <= (state_d != FLUSH);
            we       <= wr_en;
            if (wr_en) begin
                wr_address <= start ? '0 : n_q;
                gray_out   <= gray_in;
                n_q        <= start ? ONE : n_q + ONE;
            end
        end
    end

    // Center position kept as x/y counters plus a running linear index.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            cx_q <= '0;
            cy_q <= '0;
            cm_q <= '0;
        end else if (issue) begin
            if (center_last) begin
                cx_q <= '0;
                cy_q <= '0;
                cm_q <= '0;
            end else if (cx_q == X_LAST) begin
                cx_q <= '0;
                cy_q <= cy_q + 9'd1;
                cm_q <= cm_q + ONE;
            end else begin
                cx_q <= cx_q + 10'd1;
                cm_q <= cm_q + ONE;
            end
        end
    end

    // Edge replication: a missing neighbor row/column collapses onto the center's.
    always_comb begin
        at_l  = (cx_q == 10'd0);
        at_r  = (cx_q == X_LAST);
        at_u  = (cy_q == 9'd0);
        at_d  = (cy_q == Y_LAST);
        row_u = at_u ? cm_q : cm_q - W_A;
        row_d = at_d ? cm_q : cm_q + W_A;
        nb_lu = at_l ? row_u : row_u - ONE;
        nb_u  = row_u;
        nb_ru = at_r ? row_u : row_u + ONE;
        nb_l  = at_l ? cm_q : cm_q - ONE;
        nb_r  = at_r ? cm_q : cm_q + ONE;
        nb_ld = at_l ? row_d : row_d - ONE;
        nb_d  = row_d;
        nb_rd = at_r ? row_d : row_d + ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_c  <= '0;
            addr_lu <= '0;
            addr_l  <= '0;
            addr_ld <= '0;
            addr_u  <= '0;
            addr_d  <= '0;
            addr_ru <= '0;
            addr_r  <= '0;
            addr_rd <= '0;
        end else if (issue) begin
            addr_c  <= cm_q;
            addr_lu <= nb_lu;
            addr_l  <= nb_l;
            addr_ld <= nb_ld;
            addr_u  <= nb_u;
            addr_d  <= nb_d;
            addr_ru <= nb_ru;
            addr_r  <= nb_r;
            addr_rd <= nb_rd;
        end
    end

    // Valid/last flags track the buffer's two-register read path; an abort drops in-flight windows.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            p1_vld       <= 1'b0;
            p2_vld       <= 1'b0;
            window_valid <= 1'b0;
            p1_last      <= 1'b0;
            p2_last      <= 1'b0;
            win_last     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            p1_vld       <= issue;
            p2_vld       <= p1_vld;
            window_valid <= p2_vld;
            p1_last      <= issue && center_last;
            p2_last      <= p1_last;
            win_last     <= p2_last;
            frame_done   <= window_valid && win_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_x  <= '0;
            p1_y  <= '0;
            p2_x  <= '0;
            p2_y  <= '0;
            win_x <= '0;
            win_y <= '0;
        end else begin
            if (issue) begin
                p1_x <= cx_q;
                p1_y <= cy_q;
            end
            if (p1_vld) begin
                p2_x <= p1_x;
                p2_y <= p1_y;
            end
            if (p2_vld) begin
                win_x <= p2_x;
                win_y <= p2_y;
            end
        end
    end

`ifdef LBC_BORDER_FLAG_EN
    logic p1_border, p2_border;

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_border  <= 1'b0;
            p2_border  <= 1'b0;
            win_border <= 1'b0;
        end else begin
            if (issue) begin
                p1_border <= at_l || at_r || at_u || at_d;
            end
            if (p1_vld) begin
                p2_border <= p1_border;
            end
            if (p2_vld) begin
                win_border <= p2_border;
            end
        end
    end
`endif

endmodule
